multicycle_controller: RTL and testbench
========================================

# multicycle_controller

Sequencing FSM for the multi-cycle RV32I core that replaces the single-cycle control path. It decodes the 7-bit opcode in the instruction register and drives per-state control for one shared ALU, one unified memory, the register file and the PC/IR/MDR/A/B/ALUOut registers. Datapath registers and muxes live outside this block; it only emits selects, enables and write strobes.

## Interface
- `WAIT_LIMIT`, 255: maximum cycles a memory access may wait for `mem_ready`; only used with the timeout feature.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high
- `opcode`  in  7  IR[6:0]
- `alu_bcond`  in  1  branch compare result from the ALU
- `mem_ready`  in  1  memory access complete this cycle; may be high in the same cycle as the request
- `pc_write`  out  1  PC load enable
- `pc_source`  out  1  0 = ALU result, 1 = ALUOut register
- `ir_write`  out  1  IR load enable
- `iord`  out  1  memory address: 0 = PC, 1 = ALUOut
- `mem_read`, `mem_write`  out  1 each  memory request, held until `mem_ready`
- `reg_write`  out  1  register file write enable
- `wb_sel`  out  2  0 = ALUOut, 1 = MDR, 2 = ALU result; 3 is unused
- `alu_src_a`  out  1  0 = PC, 1 = A
- `alu_src_b`  out  2  0 = B, 1 = constant 4, 2 = immediate
- `alu_op_sel`  out  2  0 = ADD, 1 = FUNCT (R/I decode), 2 = BRANCH compare
- `is_ecall`  out  1  ECALL decoded (ID state)
- `instr_done`  out  1  one-cycle pulse on the final cycle of each instruction
- `state`  out  3  current state, for debug
- `mem_timeout`  out  1  sticky timeout error flag

## Operation
- States: IF=0, ID=1, EX=2, MEM=3, WB=4, PC_INC=5, JALR_T=6, ERR=7.
- Any output not listed for a state is 0.
- **IF**
  - Drives `mem_read`=1, `iord`=0.
  - Stays in IF while `mem_ready`=0.
  - When `mem_ready`=1: `ir_write`=1, next state ID.
- **ID**
  - Drives `alu_src_a`=0, `alu_src_b`=2, ADD; ALUOut latches PC+imm.
  - ECALL (1110011): `is_ecall`=1, next state PC_INC.
  - Unsupported opcode: next state PC_INC, executed as a NOP.
  - All other opcodes: next state EX.
- **EX, by opcode**
  - R (0110011): `alu_src_a`=1, `alu_src_b`=0, FUNCT; next WB.
  - I-arith (0010011): `alu_src_a`=1, `alu_src_b`=2, FUNCT; next WB.
  - LOAD/STORE: `alu_src_a`=1, `alu_src_b`=2, ADD; next MEM.
  - BRANCH: `alu_src_a`=1, `alu_src_b`=0, BRANCH.
    - `alu_bcond`=1: `pc_write`=1, `pc_source`=1, `instr_done`=1, next IF.
    - Otherwise: next PC_INC.
  - JAL: `alu_src_a`=0, `alu_src_b`=1, ADD, `reg_write`=1, `wb_sel`=2, `pc_write`=1, `pc_source`=1, `instr_done`=1; next IF.
  - JALR: computes PC+4 and writes it to rd (`wb_sel`=2); next JALR_T. A was latched in ID, so rd==rs1 is safe.
- **JALR_T**
  - Drives `alu_src_a`=1, `alu_src_b`=2, ADD, `pc_write`=1, `pc_source`=0, `instr_done`=1; next IF.
  - The datapath clears bit 0 of the target.
- **MEM** (`iord`=1; hold until `mem_ready`)
  - Load: `mem_read`=1; on ready, MDR latches; next WB.
  - Store: `mem_write`=1; on ready, `pc_write`=1 with PC+4 (`alu_src_a`=0, `alu_src_b`=1, `pc_source`=0), `instr_done`=1; next IF.
- **WB**
  - `reg_write`=1, `wb_sel`=1 for loads, 0 otherwise.
  - Concurrently PC+4: `pc_write`=1, `pc_source`=0; `instr_done`=1; next IF.
- **PC_INC**
  - PC+4 as in WB, no register write, `instr_done`=1; next IF.
- **ERR**
  - All strobes 0; `mem_timeout`=1.
  - Exited only by reset.

## Timing
- While `reset` is high:
  - All outputs are 0.
  - Next state is IF.
  - `state` reads 0 on the first edge with reset high.
- Reset applied mid-instruction aborts it with no write strobe on that edge.
- First fetch request is in the first cycle after reset deasserts.
- Latency with `mem_ready` high on the first request cycle:
  - R/I, store: 4 cycles.
  - Load: 5 cycles.
  - Branch taken: 3 cycles.
  - Branch not taken: 4 cycles.
  - JAL, ECALL: 3 cycles.
  - JALR: 4 cycles.
- Each cycle `mem_ready` stays low adds exactly one cycle.
- `mem_read` and `mem_write` are never high together.
- `ir_write`, `pc_write`, `reg_write` and `instr_done` are Mealy outputs: they may depend combinationally on `mem_ready` and `alu_bcond`.

## Configuration
- Macro `MC_CTRL_TIMEOUT_EN`, when defined:
  - A wait counter clears on entry to IF or MEM.
  - It increments each cycle the state waits with `mem_ready`=0.
  - When the count reaches `WAIT_LIMIT`, the next state is ERR.
- When undefined:
  - The FSM waits indefinitely.
  - ERR is unreachable.
  - `mem_timeout` is tied to 0.

## Structure
- Package `mc_ctrl_pkg` holds:
  - the state enum;
  - opcode constants;
  - `wb_sel`, `alu_src_b` and `alu_op_sel` encodings.
- Sub-module `mem_wait_timer` holds the timeout counter; it is instantiated only under `MC_CTRL_TIMEOUT_EN`.

## Test plan
- **R-type, `mem_ready` tied 1:** states IF, ID, EX, WB; `reg_write` only in cycle 4 with `wb_sel`=0; one `instr_done` pulse.
- **Load with 3 wait cycles on fetch and 2 on MEM:** total 10 cycles; `ir_write` pulses exactly once; `wb_sel`=1 in WB.
- **Branch:**
  - `alu_bcond`=1: `pc_write`=1 with `pc_source`=1 in the EX cycle, then back to IF.
  - `alu_bcond`=0: passes through PC_INC, `pc_source`=0.
- **JALR:** `reg_write` with `wb_sel`=2 in EX; `pc_write` with `pc_source`=0 in JALR_T; never both in one cycle.
- **Reset mid-MEM of a store with `mem_ready`=0:** `mem_write` drops on the reset edge; `state`=0; fetch restarts after release.
- **Timeout, `MC_CTRL_TIMEOUT_EN`, `WAIT_LIMIT`=4, `mem_ready` held 0:** ERR is entered after 4 wait cycles; `mem_timeout` stays 1 until reset.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle RV32I sequencing controller.
// Optional memory-wait timeout is enabled with MC_CTRL_TIMEOUT_EN.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IF     = 3'd0,
    S_ID     = 3'd1,
    S_EX     = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_PC_INC = 3'd5,
    S_JALR_T = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  localparam logic [1:0] WB_ALUOUT = 2'd0;
  localparam logic [1:0] WB_MDR    = 2'd1;
  localparam logic [1:0] WB_ALU    = 2'd2;

  localparam logic [1:0] SRCB_B    = 2'd0;
  localparam logic [1:0] SRCB_FOUR = 2'd1;
  localparam logic [1:0] SRCB_IMM  = 2'd2;

  localparam logic [1:0] ALUOP_ADD    = 2'd0;
  localparam logic [1:0] ALUOP_FUNCT  = 2'd1;
  localparam logic [1:0] ALUOP_BRANCH = 2'd2;

  // Opcodes that take the EX path; everything else retires as a NOP.
  function automatic logic is_exec_op(input logic [6:0] op);
    return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) || (op == OP_STORE) ||
           (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive memory wait cycles and flags the cycle that reaches the
// limit. Only instantiated when MC_CTRL_TIMEOUT_EN is defined.
module mem_wait_timer #(
  parameter int WAIT_LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic wait_cycle,
  output logic expired
);

  localparam int CW = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);

  logic [CW-1:0] count_reg;

  // Waits are contiguous until ready, so clearing whenever not waiting
  // is the same as clearing on entry to IF/MEM.
  always_ff @(posedge clk) begin
    if (reset || !wait_cycle) begin
      count_reg <= '0;
    end else if (!expired) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expired = wait_cycle && (count_reg == CW'(WAIT_LIMIT - 1));

endmodule

// File: rtl/multicycle_controller.sv
// Sequencing FSM for the multi-cycle RV32I core: emits per-state datapath controls.
// Define MC_CTRL_TIMEOUT_EN to enable the memory-wait timeout and ERR state.
module multicycle_controller
  import mc_ctrl_pkg::*;
#(
  parameter int WAIT_LIMIT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic       alu_bcond,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_source,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op_sel,
  output logic       is_ecall,
  output logic       instr_done,
  output logic [2:0] state,
  output logic       mem_timeout
);

  state_t state_reg;
  state_t state_next;
  logic   timeout_hit;

  if (WAIT_LIMIT < 1) begin : g_limit_check
    $error("multicycle_controller: WAIT_LIMIT must be at least 1");
  end

`ifdef MC_CTRL_TIMEOUT_EN
  logic wait_cycle;
  assign wait_cycle = ((state_reg == S_IF) || (state_reg == S_MEM)) && !mem_ready;

  mem_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_wait_timer (
    .clk        (clk),
    .reset      (reset),
    .wait_cycle (wait_cycle),
    .expired    (timeout_hit)
  );

  assign mem_timeout = !reset && (state_reg == S_ERR);
`else
  assign timeout_hit = 1'b0;
  assign mem_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_IF;
    end else begin
      state_reg <= state_next;
    end
  end

  assign state = reset ? 3'd0 : state_reg;

  always_comb begin
    state_next = state_reg;
    pc_write   = 1'b0;
    pc_source  = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    wb_sel     = WB_ALUOUT;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_B;
    alu_op_sel = ALUOP_ADD;
    is_ecall   = 1'b0;
    instr_done = 1'b0;

    case (state_reg)
      S_IF: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write   = 1'b1;
          state_next = S_ID;
        end else if (timeout_hit) begin
          state_next = S_ERR;
        end
      end
      S_ID: begin
        // ALUOut captures PC+imm for branch/JAL targets.
        alu_src_b = SRCB_IMM;
        if (opcode == OP_ECALL) begin
          is_ecall   = 1'b1;
          state_next = S_PC_INC;
        end else if (is_exec_op(opcode)) begin
          state_next = S_EX;
        end else begin
          state_next = S_PC_INC;
        end
      end
      S_EX: begin
        case (opcode)
          OP_R: begin
            alu_src_a  = 1'b1;
            alu_op_sel = ALUOP_FUNCT;
            state_next = S_WB;
          end
          OP_I: begin
            alu_src_a  = 1'b1;
            alu_src_b  = SRCB_IMM;
            alu_op_sel = ALUOP_FUNCT;
            state_next = S_WB;
          end
          OP_LOAD, OP_STORE: begin
            alu_src_a  = 1'b1;
            alu_src_b  = SRCB_IMM;
            state_next = S_MEM;
          end
          OP_BRANCH: begin
            alu_src_a  = 1'b1;
            alu_op_sel = ALUOP_BRANCH;
            if (alu_bcond) begin
              pc_write   = 1'b1;
              pc_source  = 1'b1;
              instr_done = 1'b1;
              state_next = S_IF;
            end else begin
              state_next = S_PC_INC;
            end
          end
          OP_JAL: begin
            alu_src_b  = SRCB_FOUR;
            reg_write  = 1'b1;
            wb_sel     = WB_ALU;
            pc_write   = 1'b1;
            pc_source  = 1'b1;
            instr_done = 1'b1;
            state_next = S_IF;
          end
          OP_JALR: begin
            // Link first; target uses A, which was latched before rd is written.
            alu_src_b  = SRCB_FOUR;
            reg_write  = 1'b1;
            wb_sel     = WB_ALU;
            state_next = S_JALR_T;
          end
          default: state_next = S_PC_INC;
        endcase
      end
      S_MEM: begin
        iord = 1'b1;
        if (opcode == OP_STORE) begin
          mem_write = 1'b1;
          if (mem_ready) begin
            alu_src_b  = SRCB_FOUR;
            pc_write   = 1'b1;
            instr_done = 1'b1;
            state_next = S_IF;
          end else if (timeout_hit) begin
            state_next = S_ERR;
          end
        end else begin
          mem_read = 1'b1;
          if (mem_ready) begin
            state_next = S_WB;
          end else if (timeout_hit) begin
            state_next = S_ERR;
          end
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        wb_sel     = (opcode == OP_LOAD) ? WB_MDR : WB_ALUOUT;
        alu_src_b  = SRCB_FOUR;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        state_next = S_IF;
      end
      S_PC_INC: begin
        alu_src_b  = SRCB_FOUR;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        state_next = S_IF;
      end
      S_JALR_T: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_IMM;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        state_next = S_IF;
      end
      S_ERR: state_next = S_ERR;
      default: state_next = S_IF;
    endcase

    // Reset silences every strobe in the same cycle, aborting any access.
    if (reset) begin
      pc_write   = 1'b0;
      pc_source  = 1'b0;
      ir_write   = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      wb_sel     = WB_ALUOUT;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_B;
      alu_op_sel = ALUOP_ADD;
      is_ecall   = 1'b0;
      instr_done = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller; covers the timeout
// path too when MC_CTRL_TIMEOUT_EN is defined.
module tb_multicycle_controller;

`ifdef MC_CTRL_TIMEOUT_EN
  localparam int WL = 4;
`else
  localparam int WL = 255;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic       alu_bcond;
  logic       mem_ready;
  logic       pc_write, pc_source, ir_write, iord, mem_read, mem_write, reg_write;
  logic [1:0] wb_sel, alu_src_b, alu_op_sel;
  logic       alu_src_a, is_ecall, instr_done, mem_timeout;
  logic [2:0] state;

  typedef struct packed {
    logic [2:0] state;
    logic       pc_write;
    logic       pc_source;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op_sel;
    logic       is_ecall;
    logic       instr_done;
    logic       mem_timeout;
  } ctl_t;

  ctl_t e;
  int   checks   = 0;
  int   failures = 0;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  multicycle_controller #(.WAIT_LIMIT(WL)) dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .alu_bcond   (alu_bcond),
    .mem_ready   (mem_ready),
    .pc_write    (pc_write),
    .pc_source   (pc_source),
    .ir_write    (ir_write),
    .iord        (iord),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .reg_write   (reg_write),
    .wb_sel      (wb_sel),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_op_sel  (alu_op_sel),
    .is_ecall    (is_ecall),
    .instr_done  (instr_done),
    .state       (state),
    .mem_timeout (mem_timeout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag);
    ctl_t obs;
    #1;
    obs.state       = state;
    obs.pc_write    = pc_write;
    obs.pc_source   = pc_source;
    obs.ir_write    = ir_write;
    obs.iord        = iord;
    obs.mem_read    = mem_read;
    obs.mem_write   = mem_write;
    obs.reg_write   = reg_write;
    obs.wb_sel      = wb_sel;
    obs.alu_src_a   = alu_src_a;
    obs.alu_src_b   = alu_src_b;
    obs.alu_op_sel  = alu_op_sel;
    obs.is_ecall    = is_ecall;
    obs.instr_done  = instr_done;
    obs.mem_timeout = mem_timeout;
    checks++;
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, e);
    end
  endtask

  // IF with mem_ready high, then ID (optionally ECALL).
  task automatic fetch_decode(input string tag, input logic ecall);
    e = '0; e.state = 3'd0; e.mem_read = 1'b1; e.ir_write = 1'b1;
    chk({tag, "_if"}); tick();
    e = '0; e.state = 3'd1; e.alu_src_b = 2'd2; e.is_ecall = ecall;
    chk({tag, "_id"}); tick();
  endtask

  // Shared PC+4 retire cycle used by WB and PC_INC.
  task automatic pc_inc(input string tag, input logic [2:0] st, input logic rw, input logic [1:0] wb);
    e = '0; e.state = st; e.alu_src_b = 2'd1; e.pc_write = 1'b1; e.instr_done = 1'b1;
    e.reg_write = rw; e.wb_sel = wb;
    chk(tag); tick();
  endtask

  initial begin
    reset = 1'b1; opcode = OP_R; alu_bcond = 1'b0; mem_ready = 1'b1;
    e = '0; chk("rst_pre");
    tick();
    e = '0; chk("rst_edge");
    tick();
    reset = 1'b0;

    // R-type, memory always ready
    fetch_decode("r", 1'b0);
    e = '0; e.state = 3'd2; e.alu_src_a = 1'b1; e.alu_op_sel = 2'd1;
    chk("r_ex"); tick();
    pc_inc("r_wb", 3'd4, 1'b1, 2'd0);
    $display("txn R-type retired at %0t", $time);

    // Load with 3 fetch waits and 2 MEM waits: 10 cycles
    opcode = OP_LOAD; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      e = '0; e.state = 3'd0; e.mem_read = 1'b1;
      chk("ld_if_wait"); tick();
    end
    mem_ready = 1'b1;
    fetch_decode("ld", 1'b0);
    e = '0; e.state = 3'd2; e.alu_src_a = 1'b1; e.alu_src_b = 2'd2;
    chk("ld_ex"); tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      e = '0; e.state = 3'd3; e.iord = 1'b1; e.mem_read = 1'b1;
      chk("ld_mem_wait"); tick();
    end
    mem_ready = 1'b1;
    e = '0; e.state = 3'd3; e.iord = 1'b1; e.mem_read = 1'b1;
    chk("ld_mem_rdy"); tick();
    pc_inc("ld_wb", 3'd4, 1'b1, 2'd1);
    $display("txn LOAD retired at %0t", $time);

    // Branch taken
    opcode = OP_BRANCH; alu_bcond = 1'b1;
    fetch_decode("bt", 1'b0);
    e = '0; e.state = 3'd2; e.alu_src_a = 1'b1; e.alu_op_sel = 2'd2;
    e.pc_write = 1'b1; e.pc_source = 1'b1; e.instr_done = 1'b1;
    chk("bt_ex"); tick();
    $display("txn BRANCH taken retired at %0t", $time);

    // Branch not taken
    alu_bcond = 1'b0;
    fetch_decode("bn", 1'b0);
    e = '0; e.state = 3'd2; e.alu_src_a = 1'b1; e.alu_op_sel = 2'd2;
    chk("bn_ex"); tick();
    pc_inc("bn_pcinc", 3'd5, 1'b0, 2'd0);
    $display("txn BRANCH not-taken retired at %0t", $time);

    // JAL
    opcode = OP_JAL;
    fetch_decode("jal", 1'b0);
    e = '0; e.state = 3'd2; e.alu_src_b = 2'd1; e.reg_write = 1'b1; e.wb_sel = 2'd2;
    e.pc_write = 1'b1; e.pc_source = 1'b1; e.instr_done = 1'b1;
    chk("jal_ex"); tick();
    $display("txn JAL retired at %0t", $time);

    // JALR: link in EX, jump in JALR_T
    opcode = OP_JALR;
    fetch_decode("jalr", 1'b0);
    e = '0; e.state = 3'd2; e.alu_src_b = 2'd1; e.reg_write = 1'b1; e.wb_sel = 2'd2;
    chk("jalr_ex"); tick();
    e = '0; e.state = 3'd6; e.alu_src_a = 1'b1; e.alu_src_b = 2'd2;
    e.pc_write = 1'b1; e.instr_done = 1'b1;
    chk("jalr_t"); tick();
    $display("txn JALR retired at %0t", $time);

    // ECALL and an unsupported opcode both retire via PC_INC
    opcode = OP_ECALL;
    fetch_decode("ecall", 1'b1);
    pc_inc("ecall_pcinc", 3'd5, 1'b0, 2'd0);
    $display("txn ECALL retired at %0t", $time);
    opcode = OP_LUI;
    fetch_decode("nop", 1'b0);
    pc_inc("nop_pcinc", 3'd5, 1'b0, 2'd0);
    $display("txn unsupported-op retired at %0t", $time);

    // Store, memory ready
    opcode = OP_STORE;
    fetch_decode("st", 1'b0);
    e = '0; e.state = 3'd2; e.alu_src_a = 1'b1; e.alu_src_b = 2'd2;
    chk("st_ex"); tick();
    e = '0; e.state = 3'd3; e.iord = 1'b1; e.mem_write = 1'b1; e.alu_src_b = 2'd1;
    e.pc_write = 1'b1; e.instr_done = 1'b1;
    chk("st_mem"); tick();
    $display("txn STORE retired at %0t", $time);

    // Store stalled in MEM, aborted by reset
    fetch_decode("str", 1'b0);
    e = '0; e.state = 3'd2; e.alu_src_a = 1'b1; e.alu_src_b = 2'd2;
    chk("str_ex"); tick();
    mem_ready = 1'b0;
    e = '0; e.state = 3'd3; e.iord = 1'b1; e.mem_write = 1'b1;
    chk("str_mem_wait"); tick();
    reset = 1'b1;
    e = '0; chk("str_rst_comb");
    tick();
    e = '0; chk("str_rst_edge");
    reset = 1'b0; mem_ready = 1'b1;
    fetch_decode("str_restart", 1'b0);
    e = '0; e.state = 3'd2; e.alu_src_a = 1'b1; e.alu_src_b = 2'd2;
    chk("str2_ex"); tick();
    e = '0; e.state = 3'd3; e.iord = 1'b1; e.mem_write = 1'b1; e.alu_src_b = 2'd1;
    e.pc_write = 1'b1; e.instr_done = 1'b1;
    chk("str2_mem"); tick();
    $display("txn STORE after reset retired at %0t", $time);

    // Fetch held off for 4 cycles
    opcode = OP_R; mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e = '0; e.state = 3'd0; e.mem_read = 1'b1;
      chk("to_if_wait"); tick();
    end
`ifdef MC_CTRL_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      mem_ready = (i == 1);
      e = '0; e.state = 3'd7; e.mem_timeout = 1'b1;
      chk("to_err"); tick();
    end
    reset = 1'b1;
    e = '0; chk("to_rst");
    tick();
    reset = 1'b0;
    $display("txn timeout reached ERR and cleared by reset at %0t", $time);
`else
    for (int i = 0; i < 3; i++) begin
      e = '0; e.state = 3'd0; e.mem_read = 1'b1;
      chk("to_no_err"); tick();
    end
    $display("txn long fetch stall held in IF at %0t", $time);
`endif
    mem_ready = 1'b1;
    fetch_decode("post", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
